// File: rtl/conv_kernel_win_if.sv
// Column-in / window-out handshake bundle for conv_kernel_win.
// Signal suffixes are written from the kernel assembler's point of view.
interface conv_kernel_win_if #(
    parameter int PIXEL_W = 8,
    parameter int K       = 3,
    parameter int POS_W   = 16
);
    logic [1:0]             pad_mode_i;
    logic                   col_vld_i;
    logic                   col_rdy_o;
    logic [K*PIXEL_W-1:0]   col_dat_i;
    logic [POS_W-1:0]       col_pos_i;
    logic                   col_sol_i;
    logic                   col_eol_i;
    logic                   kernel_vld_o;
    logic                   kernel_rdy_i;
    logic [K*K*PIXEL_W-1:0] kernel_dat_o;
    logic [POS_W-1:0]       kernel_pos_o;
    logic                   err_o;

    modport slave (
        input  pad_mode_i, col_vld_i, col_dat_i, col_pos_i, col_sol_i, col_eol_i, kernel_rdy_i,
        output col_rdy_o, kernel_vld_o, kernel_dat_o, kernel_pos_o, err_o
    );

    modport master (
        output pad_mode_i, col_vld_i, col_dat_i, col_pos_i, col_sol_i, col_eol_i, kernel_rdy_i,
        input  col_rdy_o, kernel_vld_o, kernel_dat_o, kernel_pos_o, err_o
    );
endinterface

// File: rtl/conv_kernel_win.sv
// KxK kernel-window assembler: shifts one column per beat into a window, adds
// per-line edge padding (none / zero / replicate) and emits windows under valid/ready.
module conv_kernel_win #(
    parameter int PIXEL_W = 8,
    parameter int K       = 3,
    parameter int POS_W   = 16
) (
    input  logic              clk,
    input  logic              srst,
    conv_kernel_win_if.slave  bus
);
    localparam int R     = (K - 1) / 2;
    localparam int CNT_W = $clog2(K + 1);
    localparam int FL_W  = $clog2(R + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;
    typedef enum logic [1:0] {PAD_NONE = 2'd0, PAD_ZERO = 2'd1, PAD_REPL = 2'd2} pad_e;
    typedef logic [K*PIXEL_W-1:0] col_t;

    state_e             state_q;
    pad_e               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FL_W-1:0]    flush_q;
    col_t               win_q [K];
    logic [POS_W-1:0]   pos_q [K];
    logic               kvld_q;
    logic [K*K*PIXEL_W-1:0] kdat_q;
    logic [POS_W-1:0]   kpos_q;
    logic               err_q;

    col_t               win_d [K];
    logic [POS_W-1:0]   pos_d [K];
    logic [K*K*PIXEL_W-1:0] kdat_d;
    logic [CNT_W-1:0]   cnt_d;

    logic               out_free, col_rdy, col_acc;
    logic               sol_load, run_step, flush_step, shift_en, emit;
    pad_e               pad_in, mode_d;
    col_t               new_col;
    logic [POS_W-1:0]   new_pos;

    assign out_free   = ~kvld_q | bus.kernel_rdy_i;
    assign col_rdy    = (state_q != ST_FLUSH) & out_free;
    assign col_acc    = bus.col_vld_i & col_rdy;
    assign sol_load   = col_acc & bus.col_sol_i;
    assign run_step   = col_acc & ~bus.col_sol_i & (state_q == ST_RUN);
    assign flush_step = (state_q == ST_FLUSH) & out_free;
    assign shift_en   = sol_load | run_step | flush_step;
    assign emit       = shift_en & (cnt_d == CNT_W'(K));

    assign pad_in  = (bus.pad_mode_i == 2'd3) ? PAD_NONE : pad_e'(bus.pad_mode_i);
    assign mode_d  = sol_load ? pad_in : mode_q;
    // Flush pads replicate the newest column, which after the first pad is itself a copy.
    assign new_col = flush_step ? ((mode_q == PAD_REPL) ? win_q[K-1] : '0) : bus.col_dat_i;
    assign new_pos = flush_step ? pos_q[K-1] : bus.col_pos_i;

    always_comb begin
        // NOTE: every signal driven here is fully assigned on each pass, so no latch is inferred.
        for (int c = 0; c < K - 1; c++) begin
            win_d[c] = win_q[c+1];
            pos_d[c] = pos_q[c+1];
        end
        win_d[K-1] = new_col;
        pos_d[K-1] = new_pos;
        if (sol_load && mode_d != PAD_NONE) begin
            for (int c = K - 1 - R; c < K - 1; c++) begin
                win_d[c] = (mode_d == PAD_REPL) ? new_col : '0;
            end
        end

        kdat_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                kdat_d[((r*K)+c)*PIXEL_W +: PIXEL_W] = win_d[c][r*PIXEL_W +: PIXEL_W];
            end
        end

        if (sol_load) begin
            cnt_d = (mode_d == PAD_NONE) ? CNT_W'(1) : CNT_W'(R + 1);
        end else if (cnt_q == CNT_W'(K)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            mode_q  <= PAD_NONE;
            cnt_q   <= '0;
            flush_q <= '0;
            // NOTE: window and position registers are reset too, so nothing stale survives srst.
            for (int c = 0; c < K; c++) begin
                win_q[c] <= '0;
                pos_q[c] <= '0;
            end
            kvld_q  <= 1'b0;
            kdat_q  <= '0;
            kpos_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;

            if (shift_en) begin
                win_q <= win_d;
                pos_q <= pos_d;
                cnt_q <= cnt_d;
            end

            if (emit) begin
                kvld_q <= 1'b1;
                kdat_q <= kdat_d;
                kpos_q <= pos_d[R];
            end else if (bus.kernel_rdy_i) begin
                kvld_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (col_acc) begin
                        if (bus.col_sol_i) begin
                            mode_q  <= mode_d;
                            state_q <= ST_RUN;
                            err_q   <= (state_q == ST_RUN);
                        end else if (state_q == ST_IDLE) begin
                            err_q <= 1'b1;
                        end
                        if ((bus.col_sol_i || state_q == ST_RUN) && bus.col_eol_i) begin
                            if (mode_d == PAD_NONE) begin
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= ST_FLUSH;
                                flush_q <= FL_W'(R);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_free) begin
                        flush_q <= flush_q - FL_W'(1);
                        if (flush_q == FL_W'(1)) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Line-length tracker: a line shorter than K cannot produce well-defined windows.
    logic [CNT_W-1:0] line_len_q;
    logic [CNT_W-1:0] line_len_d;
    logic             line_col;

    assign line_col   = col_acc & (bus.col_sol_i | (state_q == ST_RUN));
    assign line_len_d = bus.col_sol_i ? CNT_W'(1)
                      : (line_len_q == CNT_W'(K)) ? line_len_q : line_len_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (srst) begin
            line_len_q <= '0;
        end else if (line_col) begin
            line_len_q <= line_len_d;
            if (bus.col_eol_i) begin
                a_line_len: assert (line_len_d == CNT_W'(K));
            end
        end
    end
`endif

    assign bus.col_rdy_o    = col_rdy;
    assign bus.kernel_vld_o = kvld_q;
    assign bus.kernel_dat_o = kdat_q;
    assign bus.kernel_pos_o = kpos_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_conv_kernel_win.sv
// Self-checking bench for conv_kernel_win: directed line cases plus randomized
// lines with backpressure, scored against a padded-line window model.
module tb_conv_kernel_win;
    localparam int PIXEL_W = 8;
    localparam int K       = 3;
    localparam int POS_W   = 16;
    localparam int R       = (K - 1) / 2;

    typedef logic [K*PIXEL_W-1:0]   col_t;
    typedef logic [K*K*PIXEL_W-1:0] win_t;
    typedef logic [POS_W-1:0]       pos_t;
    typedef struct packed {
        win_t dat;
        pos_t pos;
    } exp_t;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    conv_kernel_win_if #(.PIXEL_W(PIXEL_W), .K(K), .POS_W(POS_W)) kif ();

    conv_kernel_win #(.PIXEL_W(PIXEL_W), .K(K), .POS_W(POS_W)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (kif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    bit   hold_low = 1'b0;
    bit   rand_bp  = 1'b0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: pad the line per mode, then every K-wide slice is one window
    // whose position is that of its centre column.
    task automatic model_line(input logic [1:0] mode, input col_t cols[$], input pos_t poss[$],
                              input bit closed);
        col_t padc[$];
        pos_t padp[$];
        int   m;
        exp_t e;
        m = (mode == 2'd3) ? 0 : int'(mode);
        if (m != 0) begin
            for (int i = 0; i < R; i++) begin
                padc.push_back(m == 1 ? col_t'(0) : cols[0]);
                padp.push_back('0);
            end
        end
        foreach (cols[i]) begin
            padc.push_back(cols[i]);
            padp.push_back(poss[i]);
        end
        if (m != 0 && closed) begin
            for (int i = 0; i < R; i++) begin
                padc.push_back(m == 1 ? col_t'(0) : cols[cols.size()-1]);
                padp.push_back('0);
            end
        end
        for (int s = 0; s + K <= padc.size(); s++) begin
            e.dat = '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    e.dat[((r*K)+c)*PIXEL_W +: PIXEL_W] = padc[s+c][r*PIXEL_W +: PIXEL_W];
            e.pos = padp[s+R];
            exp_q.push_back(e);
        end
    endtask

    task automatic make_line(input bit directed, input int len, output col_t cols[$], output pos_t poss[$]);
        col_t c;
        pos_t base;
        cols.delete();
        poss.delete();
        base = directed ? pos_t'(0) : pos_t'($urandom_range(0, 1000));
        for (int i = 0; i < len; i++) begin
            for (int r = 0; r < K; r++)
                c[r*PIXEL_W +: PIXEL_W] = directed ? PIXEL_W'(i) : PIXEL_W'($urandom);
            cols.push_back(c);
            poss.push_back(base + pos_t'(i));
        end
    endtask

    task automatic send_col(input col_t d, input pos_t p, input bit sol, input bit eol, input logic [1:0] mode);
        int waited = 0;
        kif.col_vld_i  = 1'b1;
        kif.col_dat_i  = d;
        kif.col_pos_i  = p;
        kif.col_sol_i  = sol;
        kif.col_eol_i  = eol;
        kif.pad_mode_i = mode;
        @(negedge clk);
        while (!kif.col_rdy_o) begin
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL col_rdy_timeout: got 0, expected 1 within 200 cycles");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        kif.col_vld_i = 1'b0;
        kif.col_sol_i = 1'b0;
        kif.col_eol_i = 1'b0;
    endtask

    task automatic send_line(input logic [1:0] mode, input int len, input bit directed,
                             input bit closed, input bit gaps);
        col_t       cols[$];
        pos_t       poss[$];
        logic [1:0] md;
        make_line(directed, len, cols, poss);
        model_line(mode, cols, poss, closed);
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            md = (i == 0) ? mode : 2'($urandom_range(0, 3));
            send_col(cols[i], poss[i], i == 0, closed && i == len - 1, md);
        end
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 1000) begin
            @(posedge clk);
            waited++;
        end
        check("drain_pending_windows", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        kif.kernel_rdy_i = hold_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    initial begin : compare
        bit   prev_stall = 1'b0;
        win_t prev_dat;
        pos_t prev_pos;
        exp_t e;
        forever begin
            @(negedge clk);
            if (srst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_vld_held", kif.kernel_vld_o, 1'b1);
                check("stall_dat_held", kif.kernel_dat_o, prev_dat);
                check("stall_pos_held", kif.kernel_pos_o, prev_pos);
            end
            if (kif.err_o) err_seen++;
            if (kif.kernel_vld_o && kif.kernel_rdy_i) begin
                n_win++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_window: got pos %0d, expected no window", kif.kernel_pos_o);
                end else begin
                    e = exp_q.pop_front();
                    check("window_dat", kif.kernel_dat_o, e.dat);
                    check("window_pos", kif.kernel_pos_o, e.pos);
                end
            end
            prev_stall = kif.kernel_vld_o && !kif.kernel_rdy_i;
            prev_dat   = kif.kernel_dat_o;
            prev_pos   = kif.kernel_pos_o;
        end
    end

    initial begin : main
        col_t cols[$];
        pos_t poss[$];
        win_t saved_dat;
        pos_t saved_pos;
        int   w0;
        int   e0;
        int   len;
        int   part;
        logic [1:0] mode;

        kif.col_vld_i    = 1'b0;
        kif.col_dat_i    = '0;
        kif.col_pos_i    = '0;
        kif.col_sol_i    = 1'b0;
        kif.col_eol_i    = 1'b0;
        kif.pad_mode_i   = 2'd0;
        kif.kernel_rdy_i = 1'b1;

        @(posedge clk);
        #1;
        check("reset_kernel_vld", kif.kernel_vld_o, 1'b0);
        check("reset_kernel_dat", kif.kernel_dat_o, 0);
        check("reset_kernel_pos", kif.kernel_pos_o, 0);
        check("reset_err", kif.err_o, 1'b0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // Pin the model itself against hand-computed windows.
        make_line(1'b1, 5, cols, poss);
        model_line(2'd0, cols, poss, 1'b1);
        check("model_none_count", exp_q.size(), 3);
        check("model_none_first_dat", exp_q[0].dat, 72'h02_01_00_02_01_00_02_01_00);
        check("model_none_first_pos", exp_q[0].pos, 1);
        check("model_none_last_pos", exp_q[2].pos, 3);
        exp_q.delete();
        make_line(1'b1, 4, cols, poss);
        model_line(2'd1, cols, poss, 1'b1);
        check("model_zero_count", exp_q.size(), 4);
        check("model_zero_first_dat", exp_q[0].dat, 72'h01_00_00_01_00_00_01_00_00);
        check("model_zero_last_dat", exp_q[3].dat, 72'h00_03_02_00_03_02_00_03_02);
        check("model_zero_last_pos", exp_q[3].pos, 3);
        exp_q.delete();
        model_line(2'd2, cols, poss, 1'b1);
        check("model_repl_first_dat", exp_q[0].dat, 72'h01_00_00_01_00_00_01_00_00);
        check("model_repl_last_dat", exp_q[3].dat, 72'h03_03_02_03_03_02_03_03_02);
        exp_q.delete();

        w0 = n_win;
        send_line(2'd0, 5, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("none_l5_windows", n_win - w0, 3);

        w0 = n_win;
        send_line(2'd1, 4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("zero_flush_col_rdy_low", kif.col_rdy_o, 1'b0);
        @(negedge clk);
        check("zero_flush_col_rdy_back", kif.col_rdy_o, 1'b1);
        wait_drain();
        check("zero_l4_windows", n_win - w0, 4);

        w0 = n_win;
        send_line(2'd2, 4, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("repl_l4_windows", n_win - w0, 4);

        // Output stalled for 3 cycles in the middle of a line.
        w0 = n_win;
        fork
            send_line(2'd0, 8, 1'b1, 1'b1, 1'b0);
            begin
                repeat (5) @(negedge clk);
                hold_low = 1'b1;
                @(negedge clk);
                check("bp_vld_high", kif.kernel_vld_o, 1'b1);
                check("bp_col_rdy_low", kif.col_rdy_o, 1'b0);
                saved_dat = kif.kernel_dat_o;
                saved_pos = kif.kernel_pos_o;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_dat_stable", kif.kernel_dat_o, saved_dat);
                    check("bp_pos_stable", kif.kernel_pos_o, saved_pos);
                    check("bp_col_rdy_low", kif.col_rdy_o, 1'b0);
                end
                hold_low = 1'b0;
            end
        join
        wait_drain();
        check("bp_l8_windows", n_win - w0, 6);

        // srst with a pending window after two columns of a ZERO line.
        @(negedge clk);
        hold_low = 1'b1;
        @(posedge clk);
        #1;
        send_col({K{8'd0}}, 16'd0, 1'b1, 1'b0, 2'd1);
        send_col({K{8'd1}}, 16'd1, 1'b0, 1'b0, 2'd1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        check("srst_drops_window", kif.kernel_vld_o, 1'b0);
        hold_low = 1'b0;
        @(posedge clk);
        #1;
        w0 = n_win;
        send_line(2'd1, 4, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("after_srst_windows", n_win - w0, 4);

        // Stray non-sol column while idle.
        w0 = n_win;
        e0 = err_seen;
        send_col({K{8'h55}}, 16'd7, 1'b0, 1'b0, 2'd0);
        err_exp++;
        check("idle_nonsol_err_pulse", kif.err_o, 1'b1);
        @(posedge clk);
        #1;
        check("idle_nonsol_err_single", kif.err_o, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_nonsol_no_window", n_win - w0, 0);
        send_line(2'd0, 5, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("idle_nonsol_next_line", n_win - w0, 3);
        check("idle_nonsol_err_count", err_seen - e0, 1);

        // Randomized lines, modes, gaps, backpressure and mid-line restarts.
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            mode = 2'($urandom_range(0, 3));
            len  = $urandom_range(K, 12);
            if (n < 39 && $urandom_range(0, 7) == 0) begin
                part = $urandom_range(1, len);
                send_line(mode, part, 1'b0, 1'b0, 1'b1);
                err_exp++;
            end else begin
                send_line(mode, len, 1'b0, 1'b1, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        wait_drain();
        check("total_err_pulses", err_seen, err_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
